// File: rtl/seg_scan_ctrl_lxy.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Double-buffers display values and commits them only at frame boundaries.
module seg_scan_ctrl_lxy #(
  parameter int unsigned NUM_DIG = 8,
  parameter int unsigned DWELL   = 50000,
  parameter int unsigned BLANK   = 500
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [4*NUM_DIG-1:0]   upd_data,
  input  logic [NUM_DIG-1:0]     upd_dp,
  input  logic [NUM_DIG-1:0]     upd_en,
  output logic [3:0]             dec_code,
  input  logic [7:0]             dec_seg,
  output logic [7:0]             seg_out,
  output logic [NUM_DIG-1:0]     dig_sel,
  output logic                   frame_tick
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned IW = $clog2(NUM_DIG);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx_nxt;
  logic [4*NUM_DIG-1:0]   r_act_data;
  logic [NUM_DIG-1:0]     r_act_dp;
  logic [NUM_DIG-1:0]     r_act_en;
  logic [4*NUM_DIG-1:0]   r_pend_data;
  logic [NUM_DIG-1:0]     r_pend_dp;
  logic [NUM_DIG-1:0]     r_pend_en;
  logic                   r_pend_full;
  logic [7:0]             r_seg;
  logic [NUM_DIG-1:0]     r_sel;
  logic                   r_tick;
  logic [7:0]             w_seg_nxt;
  logic [NUM_DIG-1:0]     w_sel_nxt;
  logic                   w_cnt_last;
  logic                   w_blank_last;
  logic                   w_idx_last;
  logic                   w_frame_end;
  logic                   w_accept;

  assign w_cnt_last   = (r_cnt == CW'(DWELL - 1));
  assign w_blank_last = (r_cnt == CW'(BLANK - 1));
  assign w_idx_last   = (r_idx == IW'(NUM_DIG - 1));
  assign w_frame_end  = w_cnt_last && w_idx_last;
  assign w_accept     = upd_valid && !r_pend_full;

  assign upd_ready  = !r_pend_full;
  assign dec_code   = r_act_data[{r_idx, 2'b00} +: 4];
  assign seg_out    = r_seg;
  assign dig_sel    = r_sel;
  assign frame_tick = r_tick;

  // Next state, counters and the output image for the coming cycle.
  // When the next state is SHOW, idx and the active set are unchanged, so the
  // decoder output for the current idx is the one that will be displayed.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_last ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_seg_nxt   = 8'hFF;
    w_sel_nxt   = '1;
    case (r_state)
      ST_BLANK: if (w_blank_last) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_cnt_last)   w_state_nxt = ST_BLANK;
      default:  w_state_nxt = ST_BLANK;
    endcase
    if (w_cnt_last) w_idx_nxt = w_idx_last ? '0 : r_idx + IW'(1);
    if (w_state_nxt == ST_SHOW && r_act_en[r_idx]) begin
      w_seg_nxt = {dec_seg[7:1], dec_seg[0] & ~r_act_dp[r_idx]};
      w_sel_nxt = ~(NUM_DIG'(1) << r_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_BLANK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_act_en    <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_en   <= '0;
      r_pend_full <= 1'b0;
      r_seg       <= 8'hFF;
      r_sel       <= '1;
      r_tick      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_seg   <= w_seg_nxt;
      r_sel   <= w_sel_nxt;
      r_tick  <= w_frame_end;
      // Commit and accept are exclusive: accept needs an empty pending buffer.
      if (w_frame_end && r_pend_full) begin
        r_act_data  <= r_pend_data;
        r_act_dp    <= r_pend_dp;
        r_act_en    <= r_pend_en;
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend_data <= upd_data;
        r_pend_dp   <= upd_dp;
        r_pend_en   <= upd_en;
        r_pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl_lxy.sv
// Scoreboard bench for seg_scan_ctrl_lxy (NUM_DIG=4, DWELL=8, BLANK=2).
module tb_seg_scan_ctrl_lxy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_data = '0;
  logic [3:0]  upd_dp = '0;
  logic [3:0]  upd_en = '0;
  logic [3:0]  dec_code;
  logic [7:0]  dec_seg;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int tcyc  = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [3:0] sel;
    logic       tick;
  } out_exp_t;

  typedef struct {
    int   cyc;
    logic rdy;
  } rdy_exp_t;

  out_exp_t q_out[$];
  rdy_exp_t q_rdy[$];

  seg_scan_ctrl_lxy #(.NUM_DIG(4), .DWELL(8), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_dp(upd_dp), .upd_en(upd_en),
    .dec_code(dec_code), .dec_seg(dec_seg), .seg_out(seg_out),
    .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  // Hex decoder stand-in, active-low {a,b,c,d,e,f,g,dp}; 'A' carries its own dp.
  function automatic logic [7:0] dec_f(input logic [3:0] n);
    case (n)
      4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
      4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
      4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'hC4;  4'hB: return 8'hC1;
      4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
    endcase
  endfunction

  always_comb dec_seg = dec_f(dec_code);

  // Expected pins for n cycles of a frame starting at slot offset 0.
  task automatic push_cycles(input int start, input int n, input logic [7:0] s0,
                             input logic [7:0] s1, input logic [7:0] s2,
                             input logic [7:0] s3, input logic [3:0] en, input logic tick);
    logic [7:0] segs [4];
    logic [3:0] one;
    out_exp_t   e;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    one = 4'b0001;
    for (int o = 0; o < n; o++) begin
      int d = o / 8;
      int c = o % 8;
      e.cyc  = start + o;
      e.tick = tick && (o == 0);
      if (c < 2 || !en[d]) begin
        e.seg = 8'hFF;
        e.sel = 4'hF;
      end else begin
        e.seg = segs[d];
        e.sel = ~(one << d);
      end
      q_out.push_back(e);
    end
  endtask

  task automatic push_rdy(input int cyc, input logic r);
    rdy_exp_t e;
    e.cyc = cyc;
    e.rdy = r;
    q_rdy.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (tcyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    int n;
    n = 0;
    upd_data  = d;
    upd_dp    = dp;
    upd_en    = en;
    upd_valid = 1'b1;
    while (!upd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!upd_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: upd_ready=%b after %0d cycles, required 1", upd_ready, n);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  // Monitor: compare every queued expectation on the cycle it is due.
  always @(negedge clk) begin
    out_exp_t eo;
    rdy_exp_t er;
    while (q_out.size() > 0 && q_out[0].cyc <= tcyc) begin
      eo = q_out.pop_front();
      total++;
      if (eo.cyc < tcyc) begin
        bad++;
        $display("FAIL out_missed: cyc=%0d not checked (now %0d)", eo.cyc, tcyc);
      end else if (seg_out !== eo.seg || dig_sel !== eo.sel || frame_tick !== eo.tick) begin
        bad++;
        $display("FAIL out cyc=%0d: got seg=%h sel=%b tick=%b, expected seg=%h sel=%b tick=%b",
                 tcyc, seg_out, dig_sel, frame_tick, eo.seg, eo.sel, eo.tick);
      end
    end
    while (q_rdy.size() > 0 && q_rdy[0].cyc <= tcyc) begin
      er = q_rdy.pop_front();
      total++;
      if (er.cyc < tcyc) begin
        bad++;
        $display("FAIL rdy_missed: cyc=%0d not checked (now %0d)", er.cyc, tcyc);
      end else if (upd_ready !== er.rdy) begin
        bad++;
        $display("FAIL upd_ready cyc=%0d: got %b, expected %b", tcyc, upd_ready, er.rdy);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int b2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    b  = tcyc;
    b2 = b + 110;

    // Expected outputs for the whole run, in cycle order.
    push_cycles(b,      32, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'h0, 1'b0);
    push_cycles(b + 32, 32, 8'h03, 8'h9F, 8'h25, 8'h0D, 4'hF, 1'b1);
    push_cycles(b + 64, 32, 8'h03, 8'h9F, 8'h25, 8'h0D, 4'hF, 1'b1);
    push_cycles(b + 96, 13, 8'h03, 8'h9F, 8'h25, 8'h0D, 4'hF, 1'b1);
    push_cycles(b + 109, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'h0, 1'b0);
    push_cycles(b2,       32, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'h0, 1'b0);
    push_cycles(b2 + 32,  32, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'h0, 1'b1);
    push_cycles(b2 + 64,  32, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'h0, 1'b1);
    push_cycles(b2 + 96,  32, 8'h03, 8'h9F, 8'h25, 8'h0D, 4'hD, 1'b1);
    push_cycles(b2 + 128, 32, 8'h00, 8'h9F, 8'h25, 8'h0D, 4'hF, 1'b1);
    push_cycles(b2 + 160, 32, 8'hC4, 8'h9F, 8'h25, 8'h0D, 4'hF, 1'b1);
    push_cycles(b2 + 192, 32, 8'h1F, 8'h41, 8'h49, 8'h99, 4'hF, 1'b1);
    push_cycles(b2 + 224, 32, 8'h99, 8'h48, 8'h41, 8'h1E, 4'hF, 1'b1);
    push_cycles(b2 + 256, 32, 8'h99, 8'h48, 8'h41, 8'h1E, 4'hF, 1'b1);
    push_cycles(b2 + 288, 32, 8'h0D, 8'h25, 8'h9F, 8'h03, 4'hF, 1'b1);

    push_rdy(b, 1'b1);
    push_rdy(b + 5, 1'b1);
    push_rdy(b + 6, 1'b0);
    push_rdy(b + 31, 1'b0);
    push_rdy(b + 32, 1'b1);
    push_rdy(b + 101, 1'b0);
    push_rdy(b + 108, 1'b0);
    push_rdy(b + 109, 1'b1);
    push_rdy(b2 + 163, 1'b1);
    push_rdy(b2 + 164, 1'b0);
    push_rdy(b2 + 191, 1'b0);
    push_rdy(b2 + 192, 1'b1);
    push_rdy(b2 + 193, 1'b0);
    push_rdy(b2 + 255, 1'b1);
    push_rdy(b2 + 256, 1'b0);
    push_rdy(b2 + 287, 1'b0);
    push_rdy(b2 + 288, 1'b1);

    // Basic load: shown from the frame after the commit.
    wait_cyc(b + 5);
    send(16'h3210, 4'h0, 4'hF);

    // Pending update in flight, then a 2-cycle reset in mid-SHOW discards it.
    wait_cyc(b + 100);
    send(16'h8888, 4'hF, 4'hF);
    wait_cyc(b + 108);
    rst = 1'b1;
    wait_cyc(b + 110);
    rst = 1'b0;

    // Digit 1 disabled.
    wait_cyc(b2 + 67);
    send(16'h3210, 4'h0, 4'hD);
    // Decimal point on an '8', then decoder-supplied dp on 'A'.
    wait_cyc(b2 + 99);
    send(16'h3218, 4'h1, 4'hF);
    wait_cyc(b2 + 131);
    send(16'h321A, 4'h0, 4'hF);
    // Back-to-back updates: second waits for the frame end.
    wait_cyc(b2 + 163);
    send(16'h4567, 4'h0, 4'hF);
    send(16'h7654, 4'hA, 4'hF);
    // Update accepted on the frame-end edge itself.
    wait_cyc(b2 + 255);
    send(16'h0123, 4'h0, 4'hF);

    wait_cyc(b2 + 330);
    total++;
    if (q_out.size() != 0 || q_rdy.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d output and %0d ready entries left, expected 0",
               q_out.size(), q_rdy.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl_lxy.md
# seg_scan_ctrl_lxy

Time-multiplexed scan controller for an NUM_DIG-digit common-anode 7-segment display. It drives the existing 4-to-7 hex segment decoder one digit at a time: it presents the current digit's nibble, takes back the decoder's active-low segment pattern, merges the decimal point and blanking, and drives the one-hot active-low digit select. It sits between the register/control logic that supplies display values and the board's segment/anode pins. New display values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new values.

## Interface
- NUM_DIG, 8, number of digits scanned; legal range 2..8.
- DWELL, 50000, clock cycles per digit slot, including blanking.
- BLANK, 500, all-off cycles at the start of each slot (anti-ghosting); legal range 1..DWELL-1.

- clk  in  1  system clock; the single clock domain.
- rst  in  1  reset; synchronous, active-high.
- upd_valid  in  1  update request.
- upd_ready  out  1  the pending buffer is empty and can accept an update.
- upd_data  in  4*NUM_DIG  digit nibbles; digit i is [4i+3:4i].
- upd_dp  in  NUM_DIG  decimal point enable per digit (1 = lit).
- upd_en  in  NUM_DIG  digit enable (0 = digit blanked).
- dec_code  out  4  nibble sent to the decoder; combinational from the active register and idx.
- dec_seg  in  8  decoder output, active-low, [7:0] = a,b,c,d,e,f,g,dp.
- seg_out  out  8  registered segment pins, active-low, same bit order.
- dig_sel  out  NUM_DIG  registered digit select, active-low, one-hot or all-ones.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - active set {data, dp, en}.
  - pending set plus a pend_full flag.
  - idx, the current digit, 0..NUM_DIG-1.
  - cnt, the slot counter, 0..DWELL-1.
  - state, one of BLANK or SHOW.
- Handshake:
  - upd_ready = !pend_full.
  - On upd_valid && upd_ready, the update is latched into pending and pend_full is set.
  - upd_valid while not ready is ignored. The source holds valid until it is accepted.
- Counter: cnt increments every cycle and wraps from DWELL-1 to 0.
- FSM transitions:
  - BLANK → SHOW at the edge where cnt == BLANK-1.
  - SHOW → BLANK at the edge where cnt == DWELL-1. On the same edge, idx advances, wrapping from NUM_DIG-1 to 0.
- Frame end is the edge with cnt == DWELL-1 and idx == NUM_DIG-1. On that edge:
  - If pend_full, the pending set is copied to active and pend_full is cleared.
  - An update accepted on this same edge goes into pending. It is committed at the next frame end, not this one.
- Outputs in BLANK: seg_out = 8'hFF and dig_sel = all ones.
- Outputs in SHOW:
  - If active en[idx] = 0: seg_out = 8'hFF and dig_sel = all ones.
  - Otherwise: seg_out[7:1] = dec_seg[7:1] and seg_out[0] = dec_seg[0] & ~dp[idx]. The decoder's own dp is preserved, and dp[idx] can additionally light it. dig_sel = ~(1 << idx).
- dec_code = active data nibble [idx] at all times.

## Timing
- seg_out, dig_sel and frame_tick are registered. They reflect the state/idx/cnt value that takes effect on the same edge, so segments and select always change together.
- The slot pattern repeats every DWELL cycles: BLANK cycles dark, then DWELL-BLANK cycles lit. One frame is NUM_DIG*DWELL cycles.
- frame_tick is high for exactly the first cycle after the frame-end edge, i.e. the first BLANK cycle of digit 0.
- Commit latency: a newly committed value first appears at the first SHOW cycle of digit 0 after that frame end.
- upd_ready returns high the cycle after the frame-end edge that commits a pending update.
- Reset, in any state and at any point mid-slot or mid-frame, takes effect on the next edge:
  - idx = 0, cnt = 0, state = BLANK.
  - seg_out = 8'hFF, dig_sel = all ones, frame_tick = 0.
  - Active data, dp and en = 0, so all digits are blanked.
  - pend_full = 0 and upd_ready = 1. Any pending update is discarded.

## Test plan
All scenarios use NUM_DIG=4, DWELL=8, BLANK=2 (frame = 32 cycles).
- Reset: hold rst 2 cycles in mid-SHOW → next cycle seg_out=8'hFF, dig_sel=4'b1111, upd_ready=1, frame_tick=0; with no update, the outputs stay dark for 3 frames.
- Load data=16'h3210, en=4'b1111, dp=0 → after the frame end: digit 0 dark for 2 cycles, then dig_sel=4'b1110 and seg_out=8'h03 for 6 cycles; digits 1, 2, 3 follow with 8'h9F, 8'h25, 8'h0D; frame_tick period is 32.
- Blanking: en=4'b1101 → in digit 1's slot, dig_sel=4'b1111 and seg_out=8'hFF for all 8 cycles; the other digits are unaffected.
- Decimal point: data digit 0 = 8, dp=4'b0001 → seg_out=8'h00; data digit 0 = 4'hA with dp=0 → seg_out=8'hC4 (decoder dp kept).
- Backpressure: two updates issued back to back → first accepted, upd_ready=0 until the frame end; second accepted the cycle after frame_tick and displayed one frame later; no frame mixes values.
- Update accepted exactly on a frame-end edge → not displayed in the next frame, displayed in the one after.
